// File: rtl/ttl_gate_arbiter_pkg.sv
// Shared types and helpers for ttl_gate_arbiter: state encoding, index width and
// the round-robin next-index search.
package ttl_gate_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // The package cannot see the instance's BLOCKS, so the index is sized for the
  // largest legal requester count (8).
  localparam int MAX_BLOCKS = 8;
  localparam int IDX_W      = $clog2(MAX_BLOCKS);

  // First asserted request scanning upward from (last+1) mod blocks, with wrap.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_BLOCKS-1:0] req,
                                               input logic [IDX_W-1:0]      last,
                                               input int                    blocks);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               cand;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_BLOCKS; k++) begin
      cand = (int'(last) + k) % blocks;
      if (!found && (k <= blocks) && req[cand]) begin
        pick  = IDX_W'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ttl_7411.sv
// Bank of BLOCKS independent WIDTH_IN-input AND gates.
module ttl_7411 #(
  parameter int BLOCKS   = 1,
  parameter int WIDTH_IN = 3
) (
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y
);

  for (genvar i = 0; i < BLOCKS; i++) begin : g_gate
    assign Y[i] = &A_2D[i*WIDTH_IN +: WIDTH_IN];
  end

endmodule

// File: rtl/ttl_gate_arbiter.sv
// Round-robin arbiter sharing one AND gate between BLOCKS requesters.
// Define TTL_GATE_ARB_LOCK_EN to add the Lock port (back-to-back re-grant).
module ttl_gate_arbiter
  import ttl_gate_arbiter_pkg::*;
#(
  parameter int BLOCKS     = 3,
  parameter int WIDTH_IN   = 3,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                       Clk,
  input  logic                       Clear_bar,
  input  logic [BLOCKS-1:0]          Req,
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
`ifdef TTL_GATE_ARB_LOCK_EN
  input  logic [BLOCKS-1:0]          Lock,
`endif
  output logic [BLOCKS-1:0]          Gnt,
  output logic                       Y,
  output logic                       Valid,
  output logic                       Busy
);

  localparam logic [BLOCKS-1:0] ONE = BLOCKS'(1);

  // Rise/fall delays belong to the board-level timing model; this RTL is zero-delay.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_negative_delay_ignored
  end

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d, last_q, last_d;
  logic [WIDTH_IN-1:0]      opnd_q, opnd_d;
  logic [BLOCKS-1:0]        gnt_q, gnt_d;
  logic                     y_q, y_d, valid_q, valid_d;
  logic [MAX_BLOCKS-1:0]    req_pad;
  logic [0:0]               gate_y;

  assign req_pad = MAX_BLOCKS'(Req);

  ttl_7411 #(.BLOCKS(1), .WIDTH_IN(WIDTH_IN)) u_gate (
    .A_2D (opnd_q),
    .Y    (gate_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    opnd_d  = opnd_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (|Req) begin
          idx_d   = rr_next(req_pad, last_q, BLOCKS);
          gnt_d   = ONE << idx_d;
          opnd_d  = A_2D[idx_d*WIDTH_IN +: WIDTH_IN];
          state_d = EVAL;
        end
      end
      EVAL: begin
        y_d     = gate_y[0];
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b0;
`ifdef TTL_GATE_ARB_LOCK_EN
        // Locked holder keeps the gate: re-latch its operand, pointer untouched.
        if (Req[idx_q] && Lock[idx_q]) begin
          opnd_d  = A_2D[idx_q*WIDTH_IN +: WIDTH_IN];
          state_d = EVAL;
        end else
`endif
        begin
          gnt_d   = '0;
          last_d  = idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(BLOCKS-1);
      opnd_q  <= '0;
      gnt_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      opnd_q  <= opnd_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Gnt   = gnt_q;
  assign Y     = y_q;
  assign Valid = valid_q;
  assign Busy  = (state_q != IDLE);

endmodule
